// File: rtl/nmos_cmpq_seq.sv
// Copper WAIT/SKIP sequencer for the 15-slice beam comparator array.
// It takes one IR1/IR2 pair per handshake and loads the position into the
// slices' Q latches, then the mask into their M latches. It then gates PHI1
// into the array and evaluates the chain carry-out until the condition
// resolves, times out, or is aborted.
module nmos_cmpq_seq #(
  parameter int TMO_W   = 16,
  parameter int TMO_MAX = 0
) (
  input  logic        main_clk,
  input  logic        rst,
  input  logic        ir_vld,
  output logic        ir_rdy,
  input  logic [15:0] ir1,
  input  logic [15:0] ir2,
  input  logic        phi1,
  input  logic        blit_busy,
  input  logic        abort,
  input  logic        cmp_co,
  output logic [14:0] db,
  output logic        lq,
  output logic        lm,
  output logic        c1,
  output logic        busy,
  output logic        res_vld,
  output logic        res_hit,
  output logic        res_tmo,
  output logic        res_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADQ,
    S_LOADM,
    S_ARM,
    S_EVAL
  } state_t;

  localparam logic             TMO_EN  = (TMO_MAX != 0);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_MAX);

  state_t           state;
  logic [15:0]      ir2_q;
  logic [TMO_W-1:0] miss_cnt;

  logic             met;
  logic [TMO_W-1:0] miss_inc;

  // Condition met: beam reached position, and blitter either idle or ignored (BFD).
  assign met      = cmp_co & (ir2_q[15] | ~blit_busy);
  // Next miss count; sticks at all-ones instead of wrapping.
  assign miss_inc = (&miss_cnt) ? miss_cnt : miss_cnt + TMO_W'(1);

  // PHI1 only reaches the slices while armed; busy covers LOADQ..EVAL.
  assign c1   = phi1 & (state == S_ARM);
  assign busy = (state != S_IDLE);

  // Sequencer FSM with registered handshake, bus, strobes and result pulses.
  always_ff @(posedge main_clk or posedge rst) begin
    if (rst) begin
      // NOTE: every register here is a small control flop, so all of them are
      // reset; there is no storage array that would want to skip reset.
      state    <= S_IDLE;
      ir2_q    <= '0;
      miss_cnt <= '0;
      db       <= '0;
      lq       <= 1'b0;
      lm       <= 1'b0;
      ir_rdy   <= 1'b0;
      res_vld  <= 1'b0;
      res_hit  <= 1'b0;
      res_tmo  <= 1'b0;
      res_err  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. The pulse
      // outputs get a default first, so each one lasts exactly one cycle
      // unless a branch below re-asserts it.
      lq      <= 1'b0;
      lm      <= 1'b0;
      res_vld <= 1'b0;
      res_hit <= 1'b0;
      res_tmo <= 1'b0;
      res_err <= 1'b0;

      if (abort && (state != S_IDLE)) begin
        // Abort beats any decision in flight; no result is reported.
        state    <= S_IDLE;
        miss_cnt <= '0;
        ir_rdy   <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            ir_rdy <= 1'b1;
            if (ir_vld && ir_rdy) begin
              ir2_q    <= ir2;
              miss_cnt <= '0;
              if (!ir1[0]) begin
                // Not a WAIT/SKIP pair: report an error, load nothing.
                res_vld <= 1'b1;
                res_err <= 1'b1;
              end else begin
                state  <= S_LOADQ;
                db     <= ir1[15:1];
                lq     <= 1'b1;
                ir_rdy <= 1'b0;
              end
            end
          end

          S_LOADQ: begin
            // VP7 always takes part in the compare, so its mask bit is forced.
            db    <= {1'b1, ir2_q[14:1]};
            lm    <= 1'b1;
            state <= S_LOADM;
          end

          S_LOADM: begin
            state <= S_ARM;
          end

          S_ARM: begin
            if (phi1) state <= S_EVAL;
          end

          S_EVAL: begin
            if (!ir2_q[0] && !met) begin
              // WAIT miss: count it, then time out or re-arm.
              miss_cnt <= miss_inc;
              if (TMO_EN && (miss_inc == TMO_LIM)) begin
                res_vld <= 1'b1;
                res_tmo <= 1'b1;
                state   <= S_IDLE;
                ir_rdy  <= 1'b1;
              end else begin
                state <= S_ARM;
              end
            end else begin
              // WAIT hit, or the single SKIP evaluation.
              res_vld <= 1'b1;
              res_hit <= met;
              state   <= S_IDLE;
              ir_rdy  <= 1'b1;
            end
          end

          default: begin
            state  <= S_IDLE;
            ir_rdy <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nmos_cmpq_seq.sv
// Scoreboard bench for nmos_cmpq_seq. Two instances share the inputs except
// ir_vld: u_dut has no timeout, and u_tmo times out after 3 misses.
module tb_nmos_cmpq_seq;

  logic        main_clk = 1'b0;
  logic        rst;
  logic        ir_vld, ir_vld_t;
  logic [15:0] ir1, ir2;
  logic        phi1, blit_busy, abort, cmp_co;

  logic        ir_rdy, lq, lm, c1, busy, res_vld, res_hit, res_tmo, res_err;
  logic [14:0] db;
  logic        ir_rdy_t, lq_t, lm_t, c1_t, busy_t, res_vld_t, res_hit_t, res_tmo_t, res_err_t;
  logic [14:0] db_t;

  // Expected result: {hit, tmo, err}
  logic [2:0] q0[$];
  logic [2:0] q1[$];

  int checks = 0;
  int errors = 0;
  int c1_cnt = 0;
  int c1_t_cnt = 0;

  logic        sel;
  logic        s_rdy, s_lq, s_lm, s_c1, s_busy, s_res_vld;
  logic [14:0] s_db;
  assign s_rdy     = sel ? ir_rdy_t  : ir_rdy;
  assign s_lq      = sel ? lq_t      : lq;
  assign s_lm      = sel ? lm_t      : lm;
  assign s_c1      = sel ? c1_t      : c1;
  assign s_busy    = sel ? busy_t    : busy;
  assign s_res_vld = sel ? res_vld_t : res_vld;
  assign s_db      = sel ? db_t      : db;

  always #5 main_clk = ~main_clk;

  nmos_cmpq_seq #(.TMO_W(16), .TMO_MAX(0)) u_dut (
    .main_clk(main_clk), .rst(rst), .ir_vld(ir_vld), .ir_rdy(ir_rdy),
    .ir1(ir1), .ir2(ir2), .phi1(phi1), .blit_busy(blit_busy), .abort(abort),
    .cmp_co(cmp_co), .db(db), .lq(lq), .lm(lm), .c1(c1), .busy(busy),
    .res_vld(res_vld), .res_hit(res_hit), .res_tmo(res_tmo), .res_err(res_err)
  );

  nmos_cmpq_seq #(.TMO_W(16), .TMO_MAX(3)) u_tmo (
    .main_clk(main_clk), .rst(rst), .ir_vld(ir_vld_t), .ir_rdy(ir_rdy_t),
    .ir1(ir1), .ir2(ir2), .phi1(phi1), .blit_busy(blit_busy), .abort(abort),
    .cmp_co(cmp_co), .db(db_t), .lq(lq_t), .lm(lm_t), .c1(c1_t), .busy(busy_t),
    .res_vld(res_vld_t), .res_hit(res_hit_t), .res_tmo(res_tmo_t), .res_err(res_err_t)
  );

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every result pulse, counts c1 pulses.
  initial begin
    logic [2:0] e;
    forever begin
      @(negedge main_clk);
      if (c1)   c1_cnt++;
      if (c1_t) c1_t_cnt++;
      if (res_vld === 1'b1) begin
        if (q0.size() == 0) check("dut_unexpected_res_vld", 16'(res_vld), 16'd0);
        else begin
          e = q0.pop_front();
          check("dut_result_hit_tmo_err", 16'({res_hit, res_tmo, res_err}), 16'(e));
        end
      end
      if (res_vld_t === 1'b1) begin
        if (q1.size() == 0) check("tmo_unexpected_res_vld", 16'(res_vld_t), 16'd0);
        else begin
          e = q1.pop_front();
          check("tmo_result_hit_tmo_err", 16'({res_hit_t, res_tmo_t, res_err_t}), 16'(e));
        end
      end
    end
  end

  // Stimulus tasks start and end just after a rising edge.
  task automatic issue(input logic t, input logic [15:0] a, input logic [15:0] b);
    int n;
    sel = t;
    ir1 = a;
    ir2 = b;
    if (t) ir_vld_t = 1'b1;
    else   ir_vld   = 1'b1;
    n = 0;
    @(negedge main_clk);
    while (!s_rdy && n < 20) begin
      @(negedge main_clk);
      n++;
    end
    if (n >= 20) check("issue_ir_rdy_timeout", 16'(s_rdy), 16'd1);
    @(posedge main_clk); #1;
    ir_vld   = 1'b0;
    ir_vld_t = 1'b0;
  endtask

  task automatic loads_check(input logic [14:0] dbq, input logic [14:0] dbm);
    @(negedge main_clk);
    check("loadq_lq_lm", 16'({s_lq, s_lm}), 16'b10);
    check("loadq_db", 16'(s_db), 16'(dbq));
    check("loadq_busy_c1", 16'({s_busy, s_c1}), 16'b10);
    @(posedge main_clk); #1;
    @(negedge main_clk);
    check("loadm_lq_lm", 16'({s_lq, s_lm}), 16'b01);
    check("loadm_db", 16'(s_db), 16'(dbm));
    check("loadm_c1", 16'(s_c1), 16'd0);
    @(posedge main_clk); #1;
  endtask

  // One PHI1 in ARM cycle k; rv is res_vld sampled in cycle k+2.
  task automatic phi_pulse(input logic co, input logic bb, output logic rv);
    phi1      = 1'b1;
    cmp_co    = co;
    blit_busy = bb;
    @(negedge main_clk);
    check("arm_c1", 16'(s_c1), 16'd1);
    @(posedge main_clk); #1;
    phi1 = 1'b0;
    @(posedge main_clk); #1;
    @(negedge main_clk);
    rv = s_res_vld;
    @(posedge main_clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rv;
    int   base;
    rst = 1'b1; ir_vld = 1'b0; ir_vld_t = 1'b0; ir1 = '0; ir2 = '0;
    phi1 = 1'b0; blit_busy = 1'b0; abort = 1'b0; cmp_co = 1'b0; sel = 1'b0;

    // Reset state
    repeat (2) @(posedge main_clk); #1;
    @(negedge main_clk);
    check("rst_ir_rdy", 16'(ir_rdy), 16'd0);
    check("rst_db", 16'(db), 16'd0);
    check("rst_outputs", 16'({lq, lm, c1, busy, res_vld, res_hit, res_tmo, res_err}), 16'd0);
    @(posedge main_clk); #1;
    rst = 1'b0;
    @(negedge main_clk);
    check("rdy_before_first_edge", 16'(ir_rdy), 16'd0);
    @(posedge main_clk); #1;
    @(negedge main_clk);
    check("rdy_after_first_edge", 16'(ir_rdy), 16'd1);
    @(posedge main_clk); #1;

    // WAIT: three misses then a hit
    base = c1_cnt;
    q0.push_back(3'b100);
    issue(1'b0, 16'h2C01, 16'hFFFE);
    loads_check(15'h1600, 15'h7FFF);
    for (int i = 0; i < 3; i++) begin
      phi_pulse(1'b0, 1'b0, rv);
      check("wait_miss_no_result", 16'(rv), 16'd0);
    end
    phi_pulse(1'b1, 1'b0, rv);
    check("wait_hit_res_vld_k2", 16'(rv), 16'd1);
    check("wait_c1_count", 16'(c1_cnt - base), 16'd4);

    // SKIP miss, then SKIP hit
    base = c1_cnt;
    q0.push_back(3'b000);
    issue(1'b0, 16'h2C01, 16'hFFFF);
    loads_check(15'h1600, 15'h7FFF);
    phi_pulse(1'b0, 1'b0, rv);
    check("skip_miss_res_vld", 16'(rv), 16'd1);
    check("skip_c1_count", 16'(c1_cnt - base), 16'd1);
    q0.push_back(3'b100);
    issue(1'b0, 16'h2C01, 16'hFFFF);
    loads_check(15'h1600, 15'h7FFF);
    phi_pulse(1'b1, 1'b0, rv);
    check("skip_hit_res_vld", 16'(rv), 16'd1);

    // BFD clear: blitter busy holds off the WAIT
    q0.push_back(3'b100);
    issue(1'b0, 16'hA201, 16'h0AAA);
    loads_check(15'h5100, 15'h4555);
    phi_pulse(1'b1, 1'b1, rv);
    check("bfd_blit_busy_miss1", 16'(rv), 16'd0);
    phi_pulse(1'b1, 1'b1, rv);
    check("bfd_blit_busy_miss2", 16'(rv), 16'd0);
    phi_pulse(1'b1, 1'b0, rv);
    check("bfd_blit_idle_hit", 16'(rv), 16'd1);
    blit_busy = 1'b0;

    // Timeout after 3 misses on the TMO_MAX=3 instance
    base = c1_t_cnt;
    q1.push_back(3'b010);
    issue(1'b1, 16'h2C01, 16'hFFFE);
    loads_check(15'h1600, 15'h7FFF);
    phi_pulse(1'b0, 1'b0, rv);
    check("tmo_miss1", 16'(rv), 16'd0);
    phi_pulse(1'b0, 1'b0, rv);
    check("tmo_miss2", 16'(rv), 16'd0);
    phi_pulse(1'b0, 1'b0, rv);
    check("tmo_res_vld", 16'(rv), 16'd1);
    check("tmo_c1_count", 16'(c1_t_cnt - base), 16'd3);
    sel = 1'b0;

    // Error: IR1[0]=0
    base = c1_cnt;
    q0.push_back(3'b001);
    issue(1'b0, 16'h2C00, 16'hFFFE);
    @(negedge main_clk);
    check("err_no_loads", 16'({lq, lm, busy}), 16'd0);
    check("err_res_vld_next", 16'(res_vld), 16'd1);
    check("err_ir_rdy", 16'(ir_rdy), 16'd1);
    @(posedge main_clk); #1;
    check("err_c1_count", 16'(c1_cnt - base), 16'd0);

    // Abort in ARM
    issue(1'b0, 16'h2C01, 16'hFFFF);
    loads_check(15'h1600, 15'h7FFF);
    abort = 1'b1;
    @(posedge main_clk); #1;
    abort = 1'b0;
    @(negedge main_clk);
    check("abort_arm_idle", 16'({busy, ir_rdy}), 16'b01);
    repeat (3) @(posedge main_clk); #1;

    // Abort coinciding with the EVAL decision
    issue(1'b0, 16'h2C01, 16'hFFFE);
    loads_check(15'h1600, 15'h7FFF);
    phi1 = 1'b1; cmp_co = 1'b1;
    @(posedge main_clk); #1;
    phi1 = 1'b0; abort = 1'b1;
    @(posedge main_clk); #1;
    abort = 1'b0;
    @(negedge main_clk);
    check("abort_eval_no_result", 16'({res_vld, busy}), 16'd0);
    repeat (2) @(posedge main_clk); #1;

    // PHI1 during LOADQ/LOADM is ignored
    base = c1_cnt;
    q0.push_back(3'b100);
    issue(1'b0, 16'h2C01, 16'hFFFF);
    phi1 = 1'b1;
    loads_check(15'h1600, 15'h7FFF);
    phi1 = 1'b0;
    @(negedge main_clk);
    check("phi_in_load_no_c1", 16'(c1_cnt - base), 16'd0);
    @(posedge main_clk); #1;
    phi_pulse(1'b1, 1'b0, rv);
    check("phi_in_load_then_hit", 16'(rv), 16'd1);
    check("phi_in_load_c1_count", 16'(c1_cnt - base), 16'd1);

    // Reset asserted mid-LOADM clears outputs at once
    issue(1'b0, 16'h2C01, 16'hFFFE);
    @(posedge main_clk); #1;
    @(negedge main_clk);
    check("pre_rst_lm", 16'(lm), 16'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_db", 16'(db), 16'd0);
    check("rst_mid_outputs", 16'({ir_rdy, lq, lm, c1, busy, res_vld}), 16'd0);
    #2;
    rst = 1'b0;
    @(posedge main_clk); #1;
    @(negedge main_clk);
    check("rst_mid_rdy_after", 16'(ir_rdy), 16'd1);

    repeat (3) @(posedge main_clk); #1;
    check("dut_queue_drained", 16'(q0.size()), 16'd0);
    check("tmo_queue_drained", 16'(q1.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nmos_cmpq_seq.md
# nmos_cmpq_seq

Copper-style WAIT/SKIP sequencer for the 15-slice beam comparator array. It accepts one instruction pair (IR1, IR2) per handshake and loads the position into the slices' Q latches and the mask into their M latches over the shared data bus. It then gates PHI1 into the array and evaluates the chain carry-out (masked beam >= masked position) until the condition resolves. It sits between the copper instruction fetch and the comparator array.

## Interface
- TMO_W, 16, width of WAIT timeout counter
- TMO_MAX, 0, PHI1 evaluations allowed before a WAIT times out; 0 disables timeout
- main_clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- ir_vld  in  1  instruction pair valid
- ir_rdy  out  1  sequencer can accept an instruction
- ir1  in  16  IR1: [15:1] position (VP7..VP0, HP8..HP2), [0] must be 1
- ir2  in  16  IR2: [15] BFD, [14:1] mask, [0] 0=WAIT, 1=SKIP
- phi1  in  1  one-cycle PHI1 strobe from clock generator
- blit_busy  in  1  blitter busy
- abort  in  1  cancel current instruction
- cmp_co  in  1  carry-out of MSB slice; 1 = masked beam >= masked position
- db  out  15  data bus to slices
- lq  out  1  load-position strobe (all slices)
- lm  out  1  load-mask strobe (all slices)
- c1  out  1  gated PHI1 to slices
- busy  out  1  instruction in progress
- res_vld  out  1  one-cycle result pulse
- res_hit  out  1  condition met (valid with res_vld)
- res_tmo  out  1  WAIT timed out (valid with res_vld)
- res_err  out  1  IR1[0]=0, not a WAIT/SKIP (valid with res_vld)

## Operation
- States: IDLE, LOADQ, LOADM, ARM, EVAL.
- IDLE: ir_rdy=1, busy=0. On ir_vld, capture ir1/ir2. If ir1[0]=0, stay IDLE and pulse res_vld+res_err next cycle with no loads. Otherwise go to LOADQ.
- LOADQ: db=ir1[15:1], lq=1 for exactly one cycle, then LOADM.
- LOADM: db={1'b1, ir2[14:1]}. VP7 is always compared (mask bit 14 forced to 1). lm=1 for one cycle, then ARM.
- ARM: c1=phi1 (combinational gate); c1=0 in every other state. On phi1, go to EVAL.
- EVAL: met = cmp_co & (ir2[15] | ~blit_busy).
  - WAIT: if met, result hit=1. Otherwise increment the miss counter and return to ARM. If TMO_MAX!=0 and the incremented count equals TMO_MAX, result tmo=1, hit=0.
  - SKIP: single evaluation; result hit=met.
  - Result → IDLE.
- db holds its last driven value outside LOADQ/LOADM. lq and lm are never asserted together.
- abort in any non-IDLE state: go to IDLE next edge, no res_vld, miss counter cleared. abort in IDLE is ignored. If abort coincides with an EVAL decision, abort wins.
- Miss counter: TMO_W bits, cleared on every accept. It saturates and does not wrap when TMO_MAX=0.
- busy=1 in LOADQ..EVAL.

## Timing
- Reset: state IDLE; ir_rdy=0 while rst is high, 1 from the first edge after release. db=0; lq, lm, c1, busy, res_* all 0; miss counter 0.
- Accept at edge 0 (ir_vld & ir_rdy): LOADQ during cycle 1, LOADM during cycle 2, ARM from cycle 3.
- A phi1 seen in cycles 1–2 is ignored; c1 stays 0 and no evaluation is counted.
- phi1 in ARM cycle k: c1=1 in cycle k, EVAL in cycle k+1, res_vld and ir_rdy=1 in cycle k+2.
- Minimum instruction latency (phi1 in cycle 3): res_vld in cycle 5.
- A new ir_vld in the res_vld cycle is accepted. Back-to-back throughput is 1 instruction per 5 cycles minimum.
- res_err pulse occurs in the cycle after the accept edge; ir_rdy stays 1.

## Test plan
- WAIT ir1=0x2C01, ir2=0xFFFE, model cmp_co=0 for 3 phi1 then 1 -> lq cycle 1 with db=0x1600, lm cycle 2 with db=0x7FFF, 4 c1 pulses, res_vld with hit=1 two cycles after the 4th phi1.
- SKIP ir2=0xFFFF, cmp_co=0 at first phi1 -> single c1, res_vld hit=0; repeat with cmp_co=1 -> hit=1.
- BFD: ir2[15]=0, blit_busy=1, cmp_co=1 -> WAIT keeps re-arming; drop blit_busy -> hit=1 on next evaluation.
- TMO_MAX=3, WAIT, cmp_co=0 -> exactly 3 c1 pulses, res_vld tmo=1 hit=0.
- ir1=0x2C00 -> no lq/lm/c1; res_vld err=1 next cycle. Then abort in ARM -> idle next edge, no res_vld; assert rst mid-LOADM -> all outputs 0 immediately.
- phi1 asserted during LOADQ and LOADM cycles -> c1 stays 0; first c1 only in ARM.
